// File: rtl/pwm_output_gen.sv
// pwm_output_gen: turns an 8-bit duty word into a 256-tick PWM waveform.
// The applied duty only changes at period boundaries. An optional slew
// limiter ramps the applied duty toward the requested value.
//
// Parameters:
//   PRESCALE  - clk cycles per PWM tick (1..65535)
//   SLEW_STEP - max duty change per slew update (0 = limiter bypassed, <=255)
//   SLEW_DIV  - period boundaries between slew updates (1..255)
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-high reset
//   enable       - run/stop control
//   duty_in      - requested duty (8 bits)
//   pwm_out      - registered PWM output
//   period_start - one-cycle pulse on the first cycle of each period
//   duty_active  - duty currently applied
module pwm_output_gen #(
   parameter int unsigned PRESCALE  = 195,
   parameter int unsigned SLEW_STEP = 0,
   parameter int unsigned SLEW_DIV  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] duty_in,
   output logic       pwm_out,
   output logic       period_start,
   output logic [7:0] duty_active
);

   localparam int unsigned DUTY_W = 8;
   localparam int unsigned PRE_W  = 16;
   localparam int unsigned SLEW_W = DUTY_W + 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [DUTY_W-1:0] SDIV_LAST = DUTY_W'(SLEW_DIV - 1);
   localparam logic [DUTY_W-1:0] CNT_LAST  = DUTY_W'(255);
   localparam logic [SLEW_W-1:0] STEP_W9   = SLEW_W'(SLEW_STEP);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [DUTY_W-1:0]   duty_q;
   logic [PRE_W-1:0]    pre_cnt;
   logic [PRE_W-1:0]    pre_cnt_d;
   logic [DUTY_W-1:0]   cnt;
   logic [DUTY_W-1:0]   cnt_d;
   logic [DUTY_W-1:0]   slew_cnt;
   logic [DUTY_W-1:0]   slew_cnt_d;
   logic [DUTY_W-1:0]   duty_active_d;
   logic                pwm_d;
   logic                period_start_d;

   logic                tick;
   logic                boundary;
   logic                slew_due;
   logic [SLEW_W-1:0]   req_w9;
   logic [SLEW_W-1:0]   up_sum;
   logic [SLEW_W-1:0]   dn_diff;
   logic [DUTY_W-1:0]   slew_val;

   // Tick / boundary detection
   assign tick     = (pre_cnt == PRE_LAST);
   assign boundary = tick && (cnt == CNT_LAST);
   assign slew_due = (slew_cnt == SDIV_LAST);

   // Slew candidate: 9-bit math so the step can neither wrap nor overshoot
   always_comb begin
      req_w9   = {1'b0, duty_q};
      up_sum   = {1'b0, duty_active} + STEP_W9;
      dn_diff  = {1'b0, duty_active} - STEP_W9;
      slew_val = duty_active;
      if (duty_q > duty_active) begin
         slew_val = (up_sum > req_w9) ? duty_q : up_sum[DUTY_W-1:0];
      end else if (duty_q < duty_active) begin
         // bit 8 set means the subtraction borrowed past zero
         slew_val = (dn_diff[DUTY_W] || (dn_diff < req_w9)) ? duty_q : dn_diff[DUTY_W-1:0];
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d        = state_q;
      pre_cnt_d      = pre_cnt;
      cnt_d          = cnt;
      slew_cnt_d     = slew_cnt;
      duty_active_d  = duty_active;
      pwm_d          = 1'b0;
      period_start_d = 1'b0;

      case (state_q)
         IDLE: begin
            pre_cnt_d     = '0;
            cnt_d         = '0;
            slew_cnt_d    = '0;
            duty_active_d = '0;
            if (enable) begin
               state_d        = RUN;
               period_start_d = 1'b1;
               duty_active_d  = (SLEW_STEP == 0) ? duty_q : '0;
            end
         end

         RUN: begin
            if (!enable) begin
               // Stop wins over a coincident boundary
               state_d       = IDLE;
               pre_cnt_d     = '0;
               cnt_d         = '0;
               slew_cnt_d    = '0;
               duty_active_d = '0;
            end else begin
               pwm_d     = (cnt < duty_active);
               pre_cnt_d = tick ? '0 : pre_cnt + PRE_W'(1);
               if (tick) begin
                  cnt_d = cnt + DUTY_W'(1);
               end
               if (boundary) begin
                  period_start_d = 1'b1;
                  if (SLEW_STEP == 0) begin
                     duty_active_d = duty_q;
                  end else if (slew_due) begin
                     slew_cnt_d    = '0;
                     duty_active_d = slew_val;
                  end else begin
                     slew_cnt_d = slew_cnt + DUTY_W'(1);
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         duty_q       <= '0;
         pre_cnt      <= '0;
         cnt          <= '0;
         slew_cnt     <= '0;
         duty_active  <= '0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state_q      <= state_d;
         duty_q       <= duty_in;
         pre_cnt      <= pre_cnt_d;
         cnt          <= cnt_d;
         slew_cnt     <= slew_cnt_d;
         duty_active  <= duty_active_d;
         pwm_out      <= pwm_d;
         period_start <= period_start_d;
      end
   end

endmodule

// File: tb/tb_pwm_output_gen.sv
// Bench for pwm_output_gen: three instances with different parameter sets,
// a per-cycle arithmetic model, and directed literal expectations.
module tb_pwm_output_gen;

   localparam int N = 3;
   localparam int P_PRE  [N] = '{1, 1, 2};
   localparam int P_STEP [N] = '{0, 16, 8};
   localparam int P_DIV  [N] = '{4, 1, 4};

   logic       clk;
   logic       reset;
   logic [2:0] en;
   logic [7:0] din  [N];
   logic [2:0] pwm;
   logic [2:0] ps;
   logic [7:0] dact [N];

   int n_cmp = 0;
   int n_bad = 0;

   int exp1 [15] = '{0, 16, 32, 48, 64, 80, 96, 100, 84, 68, 52, 36, 20, 10, 10};
   int exp2 [9]  = '{0, 0, 0, 0, 8, 8, 8, 8, 16};

   pwm_output_gen #(.PRESCALE(1), .SLEW_STEP(0), .SLEW_DIV(4)) u_dut0 (
      .clk(clk), .reset(reset), .enable(en[0]), .duty_in(din[0]),
      .pwm_out(pwm[0]), .period_start(ps[0]), .duty_active(dact[0]));

   pwm_output_gen #(.PRESCALE(1), .SLEW_STEP(16), .SLEW_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .enable(en[1]), .duty_in(din[1]),
      .pwm_out(pwm[1]), .period_start(ps[1]), .duty_active(dact[1]));

   pwm_output_gen #(.PRESCALE(2), .SLEW_STEP(8), .SLEW_DIV(4)) u_dut2 (
      .clk(clk), .reset(reset), .enable(en[2]), .duty_in(din[2]),
      .pwm_out(pwm[2]), .period_start(ps[2]), .duty_active(dact[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string name, int i, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s dut%0d @%0t: actual=%0d required=%0d", name, i, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Time since RUN entry drives everything: tick count, period index and
   // number of boundaries seen are all derived from it arithmetically.
   bit m_run  [N];
   int m_t    [N];
   int m_dq   [N];
   int m_duty [N];
   bit m_pwm  [N];
   bit m_ps   [N];
   bit mvalid = 1'b0;

   function automatic int duty_after_boundary(int i, int cur, int req, int nb);
      if (P_STEP[i] == 0) return req;
      if ((nb % P_DIV[i]) != 0) return cur;
      if (req > cur) return (cur + P_STEP[i] < req) ? cur + P_STEP[i] : req;
      if (req < cur) return (cur - P_STEP[i] > req) ? cur - P_STEP[i] : req;
      return cur;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            m_run[i]  = 1'b0;
            m_t[i]    = 0;
            m_duty[i] = 0;
            m_pwm[i]  = 1'b0;
            m_ps[i]   = 1'b0;
         end else if (!m_run[i]) begin
            m_pwm[i] = 1'b0;
            m_t[i]   = 0;
            if (en[i]) begin
               m_run[i]  = 1'b1;
               m_ps[i]   = 1'b1;
               m_duty[i] = (P_STEP[i] == 0) ? m_dq[i] : 0;
            end else begin
               m_ps[i]   = 1'b0;
               m_duty[i] = 0;
            end
         end else if (!en[i]) begin
            m_run[i]  = 1'b0;
            m_pwm[i]  = 1'b0;
            m_ps[i]   = 1'b0;
            m_duty[i] = 0;
         end else begin
            m_pwm[i] = (((m_t[i] / P_PRE[i]) % 256) < m_duty[i]);
            m_ps[i]  = (((m_t[i] + 1) % (256 * P_PRE[i])) == 0);
            if (m_ps[i])
               m_duty[i] = duty_after_boundary(i, m_duty[i], m_dq[i],
                                               (m_t[i] + 1) / (256 * P_PRE[i]));
            m_t[i]++;
         end
         m_dq[i] = reset ? 0 : int'(din[i]);
      end
      if (reset) mvalid = 1'b1;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (mvalid) begin
         for (int i = 0; i < N; i++) begin
            check("pwm_out", i, int'(pwm[i]), int'(m_pwm[i]));
            check("period_start", i, int'(ps[i]), int'(m_ps[i]));
            check("duty_active", i, int'(dact[i]), m_duty[i]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_ps(int i, output bit ok);
      int n;
      n = 0;
      while (!ps[i] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      ok = ps[i];
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL period_start_timeout dut%0d @%0t: actual=0 required=1", i, $time);
      end
   endtask

   // Count high cycles in the period that starts at the next period_start,
   // optionally changing duty_in at offset chg_at within it.
   task automatic count_period(int i, int exp, int chg_at, int chg_val, string name);
      int c;
      bit ok;
      c = 0;
      wait_ps(i, ok);
      if (ok) begin
         for (int k = 1; k <= 256 * P_PRE[i]; k++) begin
            @(negedge clk);
            if (k == chg_at) din[i] = 8'(chg_val);
            if (pwm[i]) c++;
         end
         check(name, i, c, exp);
      end
   endtask

   task automatic next_ps(int i, int k);
      bit ok;
      if (k != 0) @(negedge clk);
      wait_ps(i, ok);
   endtask

   initial begin
      reset = 1'b1;
      en    = 3'b111;
      for (int i = 0; i < N; i++) din[i] = 8'd200;
      repeat (5) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check("rst_duty", i, int'(dact[i]), 0);
         check("rst_pwm", i, int'(pwm[i]), 0);
      end

      reset  = 1'b0;
      en     = 3'b000;
      din[0] = 8'd64;
      din[1] = 8'd100;
      din[2] = 8'd40;
      repeat (3) @(negedge clk);

      // Fixed-duty instance: basic duty, boundary latching, extremes
      en[0] = 1'b1;
      count_period(0, 64,  -1,  0,   "high_64");
      count_period(0, 64,  100, 192, "high_mid_change");
      count_period(0, 192, -1,  0,   "high_192");
      count_period(0, 192, 255, 64,  "high_bnd_change");
      count_period(0, 192, -1,  0,   "high_bnd_delayed");
      count_period(0, 64,  10,  0,   "high_64_again");
      count_period(0, 0,   10,  255, "high_zero");
      count_period(0, 255, -1,  0,   "high_255");
      count_period(0, 255, -1,  0,   "high_255_again");

      // Slew instance: ramp up to 100, then down to 10
      en[1] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         next_ps(1, k);
         check("slew_seq", 1, int'(dact[1]), exp1[k]);
         if (k == 7) din[1] = 8'd10;
      end

      // Slew divider instance with prescaler 2, then disable / re-enable
      en[2] = 1'b1;
      for (int k = 0; k < 9; k++) begin
         next_ps(2, k);
         check("slew_div_seq", 2, int'(dact[2]), exp2[k]);
      end
      repeat (10) @(negedge clk);
      check("pre_disable_pwm", 2, int'(pwm[2]), 1);
      en[2] = 1'b0;
      @(negedge clk);
      check("disable_pwm", 2, int'(pwm[2]), 0);
      check("disable_duty", 2, int'(dact[2]), 0);
      repeat (4) @(negedge clk);
      en[2] = 1'b1;
      @(negedge clk);
      check("reenable_ps", 2, int'(ps[2]), 1);
      check("reenable_duty", 2, int'(dact[2]), 0);
      for (int k = 0; k < 5; k++) begin
         next_ps(2, k);
         check("reramp_seq", 2, int'(dact[2]), exp2[k]);
      end

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
